// File: rtl/picorv32_sram_bridge.sv
// Bridges the PicoRV32 memory port and the Caravel Wishbone slave onto one DFFRAM port,
// with a host-writable control register whose bit 0 drives the core reset.
module picorv32_sram_bridge #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter logic [31:0] WB_BASE     = 32'h3000_0000,
  parameter logic [31:0] CTRL_OFFSET = 32'h0000_0800
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  core_resetn_o
);

  localparam int unsigned TAG_LSB   = ADDR_WIDTH + 2;
  localparam logic [31:0] CTRL_ADDR = WB_BASE + CTRL_OFFSET;

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_CTRL} src_t;

  state_t state_q, state_d;
  src_t   rsrc_q, rsrc_d;
  logic   last_wb_q, last_wb_d;
  logic   resp_wb_q, resp_wb_d;
  logic   ctrl0_q, ctrl0_d;

  logic                  core_in_range;
  logic                  wb_ram_hit, wb_ctrl_hit, wreq;
  logic                  ram_en_c;
  logic [3:0]            ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [31:0]           ram_wdata_c;
  logic [31:0]           resp_data;
  logic                  unused_addr_bits;

  assign core_in_range    = (mem_addr[31:TAG_LSB] == '0);
  assign wb_ram_hit       = (wbs_adr_i[31:TAG_LSB] == WB_BASE[31:TAG_LSB]);
  assign wb_ctrl_hit      = (wbs_adr_i == CTRL_ADDR);
  // Unmapped Wishbone addresses never compete for the RAM port.
  assign wreq             = wbs_cyc_i & wbs_stb_i & (wb_ram_hit | wb_ctrl_hit);
  assign unused_addr_bits = ^mem_addr[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rsrc_q    <= SRC_ZERO;
      last_wb_q <= 1'b0;
      resp_wb_q <= 1'b0;
      ctrl0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsrc_q    <= rsrc_d;
      last_wb_q <= last_wb_d;
      resp_wb_q <= resp_wb_d;
      ctrl0_q   <= ctrl0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsrc_d      = rsrc_q;
    last_wb_d   = last_wb_q;
    resp_wb_d   = resp_wb_q;
    ctrl0_d     = ctrl0_q;
    ram_en_c    = 1'b0;
    ram_we_c    = '0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    resp_data   = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    wbs_ack_o   = 1'b0;
    wbs_dat_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid || wreq) begin
          state_d = RESP;
          // On a tie the requester not served last wins.
          if (wreq && (!mem_valid || !last_wb_q)) begin
            last_wb_d   = 1'b1;
            resp_wb_d   = 1'b1;
            ram_addr_c  = wbs_adr_i[TAG_LSB-1:2];
            ram_wdata_c = wbs_dat_i;
            if (wb_ram_hit) begin
              ram_en_c = 1'b1;
              ram_we_c = wbs_sel_i & {4{wbs_we_i}};
              rsrc_d   = wbs_we_i ? SRC_ZERO : SRC_RAM;
            end else begin
              rsrc_d = wbs_we_i ? SRC_ZERO : SRC_CTRL;
              if (wbs_we_i && wbs_sel_i[0]) ctrl0_d = wbs_dat_i[0];
            end
          end else begin
            last_wb_d   = 1'b0;
            resp_wb_d   = 1'b0;
            ram_addr_c  = mem_addr[TAG_LSB-1:2];
            ram_wdata_c = mem_wdata;
            if (core_in_range) begin
              ram_en_c = 1'b1;
              ram_we_c = mem_wstrb;
              rsrc_d   = (mem_wstrb == 4'h0) ? SRC_RAM : SRC_ZERO;
            end else begin
              rsrc_d = SRC_ZERO;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        unique case (rsrc_q)
          SRC_RAM:  resp_data = ram_rdata;
          SRC_CTRL: resp_data = {31'b0, ctrl0_q};
          default:  resp_data = '0;
        endcase
        if (resp_wb_q) begin
          wbs_ack_o = 1'b1;
          wbs_dat_o = resp_data;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = resp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant-cycle RAM drive is combinational, so hold it quiet while reset is asserted.
  assign ram_en        = ram_en_c & resetn;
  assign ram_we        = ram_we_c & {4{resetn}};
  assign ram_addr      = resetn ? ram_addr_c : '0;
  assign ram_wdata     = resetn ? ram_wdata_c : '0;
  assign core_resetn_o = ctrl0_q;

endmodule

// File: doc/picorv32_sram_bridge.md
# picorv32_sram_bridge

Memory-side bridge between the PicoRV32 native memory interface, the Caravel Wishbone slave port and the DFFRAM512x32 macro. It arbitrates core and host accesses onto the single RAM port and converts the RAM's one-cycle registered read into `mem_ready` / `wbs_ack_o` handshakes. It also holds a host-writable control register that gates the core reset, so firmware is loaded over Wishbone before the core runs.

## Interface
- `ADDR_WIDTH`, 9: RAM word-address width; 512 words, 2 KiB.
- `WB_BASE`, 32'h3000_0000: Wishbone base address of the RAM window.
- `CTRL_OFFSET`, 32'h0000_0800: byte offset of the control register from `WB_BASE`.
- `clk`  in  1  system clock; `wb_clk_i` in the wrapper.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  core request valid.
- `mem_addr`  in  32  core byte address.
- `mem_wdata`  in  32  core write data.
- `mem_wstrb`  in  4  core byte strobes; 0 = read.
- `mem_ready`  out  1  core response strobe.
- `mem_rdata`  out  32  core read data.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone cycle, strobe, write enable.
- `wbs_sel_i`  in  4  Wishbone byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  Wishbone address and write data.
- `wbs_ack_o`  out  1  Wishbone acknowledge.
- `wbs_dat_o`  out  32  Wishbone read data.
- `ram_en`  out  1  RAM `EN0`.
- `ram_we`  out  4  RAM `WE0`.
- `ram_addr`  out  ADDR_WIDTH  RAM `A0`, word address.
- `ram_wdata`  out  32  RAM `Di0`.
- `ram_rdata`  in  32  RAM `Do0`; valid the cycle after a read enable.
- `core_resetn_o`  out  1  reset to PicoRV32; mirrors CTRL bit 0.

## Operation
- **Core request** (`creq`): `mem_valid`. It is in range when `mem_addr[31:ADDR_WIDTH+2]==0`. RAM word address is `mem_addr[ADDR_WIDTH+1:2]`.
- **Wishbone request** (`wreq`): `wbs_cyc_i & wbs_stb_i`, decoded as follows.
  - RAM hit: `wbs_adr_i[31:ADDR_WIDTH+2]==WB_BASE[31:ADDR_WIDTH+2]`.
  - CTRL hit: `wbs_adr_i==WB_BASE+CTRL_OFFSET`.
  - Any other address is ignored and never acknowledged.
- **FSM states**: IDLE and RESP.
  - IDLE, no request: stay in IDLE, RAM idle.
  - IDLE, one request: grant it and go to RESP.
  - IDLE, both requesting: grant the requester that was *not* granted last. `last_grant` resets to core, so the first tie goes to Wishbone.
  - RESP: always returns to IDLE after one cycle.
- **Grant cycle** (IDLE, combinational):
  - `ram_en=1` for in-range RAM targets.
  - `ram_we` = `mem_wstrb` for core; `wbs_sel_i & {4{wbs_we_i}}` for Wishbone.
  - `ram_addr` and `ram_wdata` come from the granted source.
  - Out-of-range core access: `ram_en=0`; write dropped; read returns 0.
  - CTRL write: bit 0 is loaded from `wbs_dat_i[0]` when `wbs_sel_i[0]=1`.
- **RESP**:
  - Exactly one of `mem_ready` / `wbs_ack_o` is high, for one cycle.
  - Read data is driven from `ram_rdata`, from `{31'b0, ctrl0}` for a CTRL read, or 0 for an out-of-range access.
  - `mem_rdata` and `wbs_dat_o` are 0 whenever their own strobe is low.
- **`core_resetn_o`**: equals CTRL bit 0. The core is not stalled by this block. Host accesses arbitrate fairly against core accesses.

## Timing
- **Reset values**: FSM=IDLE, `last_grant`=core, CTRL=0. All outputs are 0, including `ram_en`, `ram_we`, `mem_ready`, `wbs_ack_o` and `core_resetn_o`.
- **Latency**: request seen in IDLE at cycle N gives `mem_ready`/`wbs_ack_o` in cycle N+1, for reads and writes alike. Peak throughput is one access per 2 cycles.
- **RAM timing**: the write lands at the edge ending cycle N. Read data appears on `ram_rdata` in N+1 and is passed through combinationally.
- **Handshake assumptions**: requesters drop `mem_valid`/`stb` in N+2 after seeing the strobe at the end of N+1. Requests are never sampled in RESP, so a still-high request is not double-served.
- **Waiting requester**: the losing requester stays pending and is granted in N+2, the next IDLE cycle.
- **Wishbone drop**: if `wbs_stb_i` drops while in IDLE, no access occurs.
- **Reset mid-operation**: asynchronous reset forces IDLE and all outputs to 0 immediately. A write whose grant cycle edge completed before reset has landed; otherwise it has not. The pending response is discarded.
- **`last_grant`**: updates only at the grant edge.

## Test plan
- **Reset**: assert `resetn=0` mid-RESP -> all outputs 0 the same cycle, `core_resetn_o=0`, and the next access after release behaves as from reset.
- **Wishbone load**: write 0xDEADBEEF to 0x3000_0010 with sel=0xF, then read it back -> `ram_addr=4` and `ram_we=0xF` in the grant cycle; the read returns 0xDEADBEEF, each ack one cycle after stb.
- **CTRL register**: write 1 to 0x3000_0800 -> `core_resetn_o=1` from cycle N+1. Read it back -> 0x0000_0001. Write with sel=0 -> no change. Access to 0x3000_1000 -> no ack for 10 cycles.
- **Core byte write**: `mem_wstrb=0x2`, addr 0x14, wdata 0x0000AB00 over 0x11223344 -> subsequent read returns 0x1122AB44, `mem_ready` one cycle after valid.
- **Contention**: core and Wishbone request in the same cycle from reset -> Wishbone granted first, core granted 2 cycles later. The next tie goes to core. Neither strobe is ever high in the same cycle as the other.
- **Out-of-range core access**: read from 0x0000_0800 -> `ram_en` stays 0, `mem_ready` in N+1, `mem_rdata=0`. Write there -> RAM contents unchanged.
